// File: rtl/render_pkg.sv
// Shared types and frame constants for the raster render path.
package render_pkg;

    localparam int FRAME_WIDTH  = 512;
    localparam int FRAME_HEIGHT = 384;

    typedef logic [11:0] rgb12_t;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
    } pixel_coord_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } raster_state_t;

endpackage

// File: rtl/coord_fifo.sv
// Synchronous coordinate FIFO holding the in-flight shade requests in issue order.
module coord_fifo
    import render_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         push_i,
    input  pixel_coord_t push_data_i,
    input  logic         pop_i,
    output pixel_coord_t pop_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

    pixel_coord_t  mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          pushOk, popOk;

    assign full_o     = (count_q == DEPTH_CNT);
    assign empty_o    = (count_q == '0);
    assign pushOk     = push_i && !full_o;
    assign popOk      = pop_i && !empty_o;
    assign pop_data_o = mem_q[rdPtr_q];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushOk) begin
            wrPtr_d = (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
        end
        if (popOk) begin
            rdPtr_d = (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
        end
        // Occupancy only moves when exactly one side transfers.
        if (pushOk && !popOk) begin
            count_d = count_q + 1'b1;
        end else if (popOk && !pushOk) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/block_raster_sequencer.sv
// Walks the frame in raster order issuing shade requests, then pairs in-order
// shader responses with their coordinates to form the frame-buffer write stream.
module block_raster_sequencer
    import render_pkg::*;
#(
    parameter int WIDTH        = FRAME_WIDTH,
    parameter int HEIGHT       = FRAME_HEIGHT,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_start,
    output logic        shade_req_valid,
    input  logic        shade_req_ready,
    output logic [10:0] shade_req_x,
    output logic [9:0]  shade_req_y,
    input  logic        shade_resp_valid,
    input  logic [11:0] shade_resp_rgb,
    input  logic        shade_resp_hit,
    output logic [10:0] x_out_block,
    output logic [9:0]  y_out_block,
    output logic [3:0]  r_out_formatted,
    output logic [3:0]  g_out_formatted,
    output logic [3:0]  b_out_formatted,
    output logic        block_visible,
    output logic        valid_out,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  overrun_count,
    output logic        proto_err
);

    localparam logic [10:0] LAST_X = 11'(WIDTH - 1);
    localparam logic [9:0]  LAST_Y = 10'(HEIGHT - 1);

    raster_state_t state_q, state_d;
    logic [10:0]   issueX_q, issueX_d;
    logic [9:0]    issueY_q, issueY_d;
    logic          reqValid, handshake, respPop;
    logic          fifoFull, fifoEmpty;
    pixel_coord_t  issueCoord, headCoord;

    logic [10:0]   outX_q;
    logic [9:0]    outY_q;
    rgb12_t        outRgb_q;
    logic          outHit_q;
    logic          outValid_q;
    logic          frameDone_q;
    logic [7:0]    overrun_q;
    logic          protoErr_q;

    assign issueCoord = '{x: issueX_q, y: issueY_q};
    assign handshake  = reqValid && shade_req_ready;
    assign respPop    = shade_resp_valid && !fifoEmpty;

    coord_fifo #(
        .DEPTH(MAX_INFLIGHT)
    ) u_coord_fifo (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .push_i     (handshake),
        .push_data_i(issueCoord),
        .pop_i      (shade_resp_valid),
        .pop_data_o (headCoord),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    always_comb begin
        state_d  = state_q;
        issueX_d = issueX_q;
        issueY_d = issueY_q;
        reqValid = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d  = SCAN;
                    issueX_d = '0;
                    issueY_d = '0;
                end
            end
            SCAN: begin
                reqValid = !fifoFull;
                if (handshake) begin
                    if (issueX_q == LAST_X && issueY_q == LAST_Y) begin
                        state_d  = DRAIN;
                        issueX_d = '0;
                        issueY_d = '0;
                    end else if (issueX_q == LAST_X) begin
                        issueX_d = '0;
                        issueY_d = issueY_q + 10'd1;
                    end else begin
                        issueX_d = issueX_q + 11'd1;
                    end
                end
            end
            DRAIN: begin
                // Leave once the final pixel has been presented on the write port.
                if (frameDone_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            issueX_q <= '0;
            issueY_q <= '0;
        end else begin
            state_q  <= state_d;
            issueX_q <= issueX_d;
            issueY_q <= issueY_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            outX_q      <= '0;
            outY_q      <= '0;
            outRgb_q    <= '0;
            outHit_q    <= 1'b0;
            outValid_q  <= 1'b0;
            frameDone_q <= 1'b0;
            overrun_q   <= '0;
            protoErr_q  <= 1'b0;
        end else begin
            outValid_q  <= respPop;
            frameDone_q <= respPop && headCoord.x == LAST_X && headCoord.y == LAST_Y;
            if (respPop) begin
                outX_q   <= headCoord.x;
                outY_q   <= headCoord.y;
                outRgb_q <= shade_resp_rgb;
                outHit_q <= shade_resp_hit;
            end
            if (frame_start && state_q != IDLE && overrun_q != 8'hFF) begin
                overrun_q <= overrun_q + 8'd1;
            end
            if (shade_resp_valid && fifoEmpty) begin
                protoErr_q <= 1'b1;
            end
        end
    end

    assign shade_req_valid = reqValid;
    assign shade_req_x     = issueX_q;
    assign shade_req_y     = issueY_q;
    assign x_out_block     = outX_q;
    assign y_out_block     = outY_q;
    assign r_out_formatted = outRgb_q[11:8];
    assign g_out_formatted = outRgb_q[7:4];
    assign b_out_formatted = outRgb_q[3:0];
    assign block_visible   = outHit_q;
    assign valid_out       = outValid_q;
    assign busy            = (state_q != IDLE);
    assign frame_done      = frameDone_q;
    assign overrun_count   = overrun_q;
    assign proto_err       = protoErr_q;

endmodule

// File: tb/tb_block_raster_sequencer.sv
// Bench for block_raster_sequencer: a 4x2 instance driven from a vector table and an
// 8x4 instance checked against a queue-based pixel model under directed and random traffic.
module tb_block_raster_sequencer;

    localparam int SW = 4;
    localparam int SH = 2;
    localparam int W = 8;
    localparam int H = 4;
    localparam int MAXF = 8;
    localparam int TOTAL = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        frameStart;
    logic        reqReady;
    logic        respValid;
    logic [11:0] respRgb;
    logic        respHit;

    logic        reqValid, validOut, busyOut, doneOut, visOut, protoOut;
    logic [10:0] reqX, xOut;
    logic [9:0]  reqY, yOut;
    logic [3:0]  rOut, gOut, bOut;
    logic [7:0]  overrunOut;

    logic        sReqValid, sValidOut, sBusy, sDone, sVis, sProto;
    logic [10:0] sReqX, sXOut;
    logic [9:0]  sReqY, sYOut;
    logic [3:0]  sR, sG, sB;
    logic [7:0]  sOverrun;

    block_raster_sequencer #(.WIDTH(W), .HEIGHT(H), .MAX_INFLIGHT(MAXF)) dut (
        .clk_in(clk), .rst_in(rst), .frame_start(frameStart),
        .shade_req_valid(reqValid), .shade_req_ready(reqReady),
        .shade_req_x(reqX), .shade_req_y(reqY),
        .shade_resp_valid(respValid), .shade_resp_rgb(respRgb), .shade_resp_hit(respHit),
        .x_out_block(xOut), .y_out_block(yOut),
        .r_out_formatted(rOut), .g_out_formatted(gOut), .b_out_formatted(bOut),
        .block_visible(visOut), .valid_out(validOut), .busy(busyOut),
        .frame_done(doneOut), .overrun_count(overrunOut), .proto_err(protoOut)
    );

    block_raster_sequencer #(.WIDTH(SW), .HEIGHT(SH), .MAX_INFLIGHT(MAXF)) dutSmall (
        .clk_in(clk), .rst_in(rst), .frame_start(frameStart),
        .shade_req_valid(sReqValid), .shade_req_ready(reqReady),
        .shade_req_x(sReqX), .shade_req_y(sReqY),
        .shade_resp_valid(respValid), .shade_resp_rgb(respRgb), .shade_resp_hit(respHit),
        .x_out_block(sXOut), .y_out_block(sYOut),
        .r_out_formatted(sR), .g_out_formatted(sG), .b_out_formatted(sB),
        .block_visible(sVis), .valid_out(sValidOut), .busy(sBusy),
        .frame_done(sDone), .overrun_count(sOverrun), .proto_err(sProto)
    );

    typedef struct {
        bit          fs;
        bit          rdy;
        bit          rv;
        logic [11:0] rgb;
        bit          hit;
        bit          eValid;
        int          eX;
        int          eY;
        logic [11:0] eRgb;
        bit          eHit;
        bit          eDone;
        bit          eBusy;
    } vec_t;

    vec_t tbl[12];

    int checks = 0;
    int errors = 0;

    // Reference model: pixel indices in flight, next index to issue, and expectations for this cycle.
    int          inflight[$];
    int          issueIdx;
    bit          mBusy;
    bit          expValid;
    int          expIdx;
    logic [11:0] expRgb;
    bit          expHit;
    bit          expDone;
    int          expOverrun;
    bit          expProto;
    int          hsCount = 0;
    int          doneCount = 0;

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        bit reqExp;
        reqExp = mBusy && issueIdx < TOTAL && inflight.size() < MAXF;
        checkValue("busy", int'(busyOut), int'(mBusy));
        checkValue("req_valid", int'(reqValid), int'(reqExp));
        if (reqExp) begin
            checkValue("req_x", int'(reqX), issueIdx % W);
            checkValue("req_y", int'(reqY), issueIdx / W);
        end
        checkValue("valid_out", int'(validOut), int'(expValid));
        if (expValid) begin
            checkValue("x_out", int'(xOut), expIdx % W);
            checkValue("y_out", int'(yOut), expIdx / W);
            checkValue("r_out", int'(rOut), int'(expRgb[11:8]));
            checkValue("g_out", int'(gOut), int'(expRgb[7:4]));
            checkValue("b_out", int'(bOut), int'(expRgb[3:0]));
            checkValue("visible", int'(visOut), int'(expHit));
        end
        checkValue("frame_done", int'(doneOut), int'(expDone));
        checkValue("overrun", int'(overrunOut), expOverrun);
        checkValue("proto_err", int'(protoOut), int'(expProto));
        if (doneOut) doneCount++;
    endtask

    task automatic applyStimulus(input bit fs, input bit rdy, input bit rv,
                                 input logic [11:0] rgb, input bit hit);
        bit reqExp;
        bit nextValid;
        bit nextDone;
        int occ;
        checkOutput();
        frameStart = fs;
        reqReady   = rdy;
        respValid  = rv;
        respRgb    = rgb;
        respHit    = hit;
        reqExp = mBusy && issueIdx < TOTAL && inflight.size() < MAXF;
        occ = inflight.size();
        nextValid = rv && occ > 0;
        nextDone  = 1'b0;
        if (rv && occ == 0) expProto = 1'b1;
        if (nextValid) begin
            expIdx   = inflight.pop_front();
            expRgb   = rgb;
            expHit   = hit;
            nextDone = (expIdx == TOTAL - 1);
        end
        if (reqExp && rdy) begin
            inflight.push_back(issueIdx);
            issueIdx++;
            hsCount++;
        end
        if (fs && mBusy && expOverrun < 255) expOverrun++;
        if (!mBusy && fs) begin
            mBusy    = 1'b1;
            issueIdx = 0;
        end else if (mBusy && expDone) begin
            mBusy = 1'b0;
        end
        expValid = nextValid;
        expDone  = nextDone;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        frameStart = 1'b0;
        reqReady = 1'b0;
        respValid = 1'b0;
        respRgb = '0;
        respHit = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        inflight.delete();
        issueIdx = 0;
        mBusy = 1'b0;
        expValid = 1'b0;
        expDone = 1'b0;
        expOverrun = 0;
        expProto = 1'b0;
    endtask

    task automatic runZeroLatency(input int maxCycles);
        int n = 0;
        while (mBusy && n < maxCycles) begin
            applyStimulus(1'b0, 1'b1, inflight.size() > 0, 12'($urandom), $urandom_range(0, 1) == 1);
            n++;
        end
        checkValue("frame_finished", int'(mBusy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hs0;
        int d0;
        int n;
        bit rdyPat[4];

        rst = 1'b1;
        frameStart = 1'b0;
        reqReady = 1'b0;
        respValid = 1'b0;
        respRgb = '0;
        respHit = 1'b0;

        for (int k = 0; k < 12; k++) begin
            tbl[k].fs     = (k == 0);
            tbl[k].rdy    = 1'b1;
            tbl[k].rv     = (k >= 2 && k <= 9);
            tbl[k].rgb    = 12'(k * 273 + 5);
            tbl[k].hit    = (k % 2 == 1);
            tbl[k].eValid = (k >= 3 && k <= 10);
            tbl[k].eX     = (k >= 3) ? (k - 3) % SW : 0;
            tbl[k].eY     = (k >= 3) ? (k - 3) / SW : 0;
            tbl[k].eRgb   = 12'((k - 1) * 273 + 5);
            tbl[k].eHit   = ((k - 1) % 2 == 1);
            tbl[k].eDone  = (k == 10);
            tbl[k].eBusy  = (k >= 1 && k <= 10);
        end

        $display("[TB] reset");
        doReset(2);
        checkValue("rst_req_valid", int'(reqValid), 0);
        checkValue("rst_req_x", int'(reqX), 0);
        checkValue("rst_req_y", int'(reqY), 0);
        checkValue("rst_x_out", int'(xOut), 0);
        checkValue("rst_y_out", int'(yOut), 0);
        checkValue("rst_rgb", int'({rOut, gOut, bOut}), 0);
        checkValue("rst_visible", int'(visOut), 0);
        checkValue("rst_valid_out", int'(validOut), 0);
        checkValue("rst_busy", int'(busyOut), 0);
        checkValue("rst_done", int'(doneOut), 0);
        checkValue("rst_overrun", int'(overrunOut), 0);
        checkValue("rst_proto", int'(protoOut), 0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);

        $display("[TB] 4x2 frame table");
        for (int k = 0; k < 12; k++) begin
            checkValue("t_busy", int'(sBusy), int'(tbl[k].eBusy));
            checkValue("t_valid", int'(sValidOut), int'(tbl[k].eValid));
            if (tbl[k].eValid) begin
                checkValue("t_x", int'(sXOut), tbl[k].eX);
                checkValue("t_y", int'(sYOut), tbl[k].eY);
                checkValue("t_r", int'(sR), int'(tbl[k].eRgb[11:8]));
                checkValue("t_g", int'(sG), int'(tbl[k].eRgb[7:4]));
                checkValue("t_b", int'(sB), int'(tbl[k].eRgb[3:0]));
                checkValue("t_hit", int'(sVis), int'(tbl[k].eHit));
            end
            checkValue("t_done", int'(sDone), int'(tbl[k].eDone));
            frameStart = tbl[k].fs;
            reqReady   = tbl[k].rdy;
            respValid  = tbl[k].rv;
            respRgb    = tbl[k].rgb;
            respHit    = tbl[k].hit;
            @(posedge clk);
            #1;
        end

        $display("[TB] in-flight cap");
        doReset(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h0, 1'b0);
        hs0 = hsCount;
        repeat (12) applyStimulus(1'b0, 1'b1, 1'b0, 12'($urandom), 1'b0);
        checkValue("cap_handshakes", hsCount - hs0, 8);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 12'($urandom), $urandom_range(0, 1) == 1);
        hs0 = hsCount;
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 12'($urandom), 1'b0);
        checkValue("release_handshakes", hsCount - hs0, 3);
        runZeroLatency(200);

        $display("[TB] overrun and protocol error");
        doReset(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h0, 1'b0);
        repeat (300) applyStimulus(1'b1, 1'b1, 1'b0, 12'h0, 1'b0);
        checkValue("overrun_sat", int'(overrunOut), 255);
        runZeroLatency(200);
        applyStimulus(1'b0, 1'b0, 1'b1, 12'hABC, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
        checkValue("proto_set", int'(protoOut), 1);
        checkValue("idle_resp_valid", int'(validOut), 0);

        $display("[TB] ready stall");
        doReset(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        rdyPat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, rdyPat[i], inflight.size() > 0, 12'($urandom), 1'b1);
        end
        runZeroLatency(200);

        $display("[TB] reset mid-frame");
        doReset(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
        hs0 = hsCount;
        n = 0;
        while (hsCount - hs0 < 3 && n < 20) begin
            applyStimulus(1'b0, 1'b1, inflight.size() > 0, 12'($urandom), 1'b0);
            n++;
        end
        checkValue("pre_reset_handshakes", hsCount - hs0, 3);
        d0 = doneCount;
        doReset(1);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
        checkValue("no_done_after_reset", doneCount - d0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h0, 1'b0);
        runZeroLatency(200);
        checkValue("restart_done_once", doneCount - d0, 1);

        $display("[TB] random traffic");
        doReset(2);
        for (int f = 0; f < 4; f++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 12'h0, 1'b0);
            n = 0;
            while (mBusy && n < 2000) begin
                applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                              inflight.size() > 0 && $urandom_range(0, 2) != 0,
                              12'($urandom), $urandom_range(0, 1) == 1);
                n++;
            end
            checkValue("rand_frame_end", int'(mBusy), 0);
            repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 12'h0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
